// File: rtl/sample_rate_sequencer.sv
`timescale 1ns/1ps
// Maps a host rate index to DCM_CLKGEN M/D, pulses the programming trigger, supervises PROGDONE/LOCKED
// with timeouts and holds the SPI engine off while the clock changes. All outputs are registered.
module sample_rate_sequencer #(
  parameter int unsigned SEL_DEFAULT        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
  input  logic       okClk,
  input  logic       reset,
  input  logic [4:0] rate_sel,
  input  logic       rate_update,
  input  logic       DCM_prog_done,
  input  logic       dcm_locked,
  input  logic       spi_idle,
  output logic [8:0] M,
  output logic [8:0] D,
  output logic       DCM_prog_trigger,
  output logic       spi_run_enable,
  output logic       busy,
  output logic       error,
  output logic [1:0] error_code,
  output logic [4:0] active_sel
);

  typedef enum logic [2:0] {
    S_RUN,
    S_STOP,
    S_LOAD,
    S_TRIG,
    S_WAIT_DONE_LO,
    S_WAIT_DONE_HI,
    S_WAIT_LOCK,
    S_ERR
  } state_t;

  function automatic logic [17:0] md_lookup(input logic [4:0] sel);
    case (sel)
      5'd0:    md_lookup = {9'd7,   9'd125};
      5'd1:    md_lookup = {9'd7,   9'd100};
      5'd2:    md_lookup = {9'd21,  9'd250};
      5'd3:    md_lookup = {9'd14,  9'd125};
      5'd4:    md_lookup = {9'd35,  9'd250};
      5'd5:    md_lookup = {9'd21,  9'd125};
      5'd6:    md_lookup = {9'd14,  9'd75};
      5'd7:    md_lookup = {9'd28,  9'd125};
      5'd8:    md_lookup = {9'd7,   9'd25};
      5'd9:    md_lookup = {9'd7,   9'd20};
      5'd10:   md_lookup = {9'd112, 9'd250};
      5'd11:   md_lookup = {9'd14,  9'd25};
      5'd12:   md_lookup = {9'd7,   9'd10};
      5'd13:   md_lookup = {9'd21,  9'd25};
      5'd14:   md_lookup = {9'd28,  9'd25};
      5'd15:   md_lookup = {9'd35,  9'd25};
      5'd16:   md_lookup = {9'd42,  9'd25};
      5'd17:   md_lookup = {9'd56,  9'd25};
      5'd18:   md_lookup = {9'd28,  9'd15};
      5'd19:   md_lookup = {9'd14,  9'd5};
      default: md_lookup = {9'd42,  9'd25};
    endcase
  endfunction

  localparam int unsigned    LCW       = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0]    TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]     SEL_DEF   = 5'(SEL_DEFAULT);
  localparam logic [4:0]     SEL_MAX   = 5'd19;
  localparam logic [17:0]    MD_DEF    = md_lookup(SEL_DEF);

  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_IDLE  = 2'd2;
  localparam logic [1:0] ERR_DCM   = 2'd3;

  logic r_done_m, r_done_s;
  logic r_lock_m, r_lock_s;
  logic r_idle_m, r_idle_s;

  always_ff @(posedge okClk) begin
    if (reset) begin
      r_done_m <= 1'b0;
      r_done_s <= 1'b0;
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
      r_idle_m <= 1'b0;
      r_idle_s <= 1'b0;
    end else begin
      r_done_m <= DCM_prog_done;
      r_done_s <= r_done_m;
      r_lock_m <= dcm_locked;
      r_lock_s <= r_lock_m;
      r_idle_m <= spi_idle;
      r_idle_s <= r_idle_m;
    end
  end

  state_t         r_state;
  logic [15:0]    r_tmo;
  logic [LCW-1:0] r_lock_cnt;
  logic [4:0]     r_pending_sel;
  logic [17:0]    w_md;
  logic           w_sel_ok;
  logic           w_tmo;

  assign w_md     = md_lookup(r_pending_sel);
  assign w_sel_ok = (rate_sel <= SEL_MAX);
  assign w_tmo    = (r_tmo == TMO_LAST);

  // r_tmo counts cycles in the current state; every transition below clears it.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_state          <= S_WAIT_LOCK;
      r_tmo            <= 16'd0;
      r_lock_cnt       <= '0;
      r_pending_sel    <= SEL_DEF;
      M                <= MD_DEF[17:9];
      D                <= MD_DEF[8:0];
      active_sel       <= SEL_DEF;
      DCM_prog_trigger <= 1'b0;
      spi_run_enable   <= 1'b0;
      busy             <= 1'b1;
      error            <= 1'b0;
      error_code       <= 2'd0;
    end else begin
      r_tmo <= r_tmo + 16'd1;
      case (r_state)
        S_RUN: begin
          if (rate_update && !w_sel_ok) begin
            error      <= 1'b1;
            error_code <= ERR_RANGE;
          end
          if (rate_update && w_sel_ok) begin
            r_pending_sel  <= rate_sel;
            r_state        <= S_STOP;
            r_tmo          <= 16'd0;
            spi_run_enable <= 1'b0;
            busy           <= 1'b1;
          end else if (!r_lock_s) begin
            // Lost lock: hold acquisition until the clock is stable again, no reprogramming.
            r_state        <= S_WAIT_LOCK;
            r_tmo          <= 16'd0;
            r_lock_cnt     <= '0;
            spi_run_enable <= 1'b0;
            busy           <= 1'b1;
          end
        end

        S_STOP: begin
          if (r_idle_s) begin
            r_state <= S_LOAD;
            r_tmo   <= 16'd0;
          end else if (w_tmo) begin
            r_state    <= S_ERR;
            r_tmo      <= 16'd0;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_IDLE;
          end
        end

        S_LOAD: begin
          M                <= w_md[17:9];
          D                <= w_md[8:0];
          active_sel       <= r_pending_sel;
          r_state          <= S_TRIG;
          r_tmo            <= 16'd0;
          DCM_prog_trigger <= 1'b1;
        end

        S_TRIG: begin
          if (r_tmo != 16'd0) begin
            r_state          <= S_WAIT_DONE_LO;
            r_tmo            <= 16'd0;
            DCM_prog_trigger <= 1'b0;
          end
        end

        S_WAIT_DONE_LO: begin
          if (!r_done_s) begin
            r_state <= S_WAIT_DONE_HI;
            r_tmo   <= 16'd0;
          end else if (w_tmo) begin
            r_state    <= S_ERR;
            r_tmo      <= 16'd0;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_DCM;
          end
        end

        S_WAIT_DONE_HI: begin
          if (r_done_s) begin
            r_state    <= S_WAIT_LOCK;
            r_tmo      <= 16'd0;
            r_lock_cnt <= '0;
          end else if (w_tmo) begin
            r_state    <= S_ERR;
            r_tmo      <= 16'd0;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_DCM;
          end
        end

        S_WAIT_LOCK: begin
          if (r_lock_s && r_lock_cnt == LOCK_LAST) begin
            r_state        <= S_RUN;
            r_tmo          <= 16'd0;
            spi_run_enable <= 1'b1;
            busy           <= 1'b0;
          end else if (w_tmo) begin
            r_state    <= S_ERR;
            r_tmo      <= 16'd0;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= ERR_DCM;
          end else if (r_lock_s) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end else begin
            r_lock_cnt <= '0;
          end
        end

        S_ERR: begin
          if (rate_update && w_sel_ok) begin
            r_pending_sel <= rate_sel;
            r_state       <= S_STOP;
            r_tmo         <= 16'd0;
            busy          <= 1'b1;
            error         <= 1'b0;
            error_code    <= 2'd0;
          end
        end

        default: begin
          r_state          <= S_WAIT_LOCK;
          r_tmo            <= 16'd0;
          r_lock_cnt       <= '0;
          DCM_prog_trigger <= 1'b0;
          spi_run_enable   <= 1'b0;
          busy             <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_rate_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected output events, a monitor detects events on the
// DUT outputs (run enable edges, trigger pulses, error changes) and compares them in order.
module tb_sample_rate_sequencer;

  logic       okClk = 1'b0;
  logic       reset;
  logic [4:0] rate_sel;
  logic       rate_update;
  logic       DCM_prog_done;
  logic       dcm_locked;
  logic       spi_idle;
  logic [8:0] M;
  logic [8:0] D;
  logic       DCM_prog_trigger;
  logic       spi_run_enable;
  logic       busy;
  logic       error;
  logic [1:0] error_code;
  logic [4:0] active_sel;

  always #10 okClk = ~okClk;

  sample_rate_sequencer dut (
    .okClk            (okClk),
    .reset            (reset),
    .rate_sel         (rate_sel),
    .rate_update      (rate_update),
    .DCM_prog_done    (DCM_prog_done),
    .dcm_locked       (dcm_locked),
    .spi_idle         (spi_idle),
    .M                (M),
    .D                (D),
    .DCM_prog_trigger (DCM_prog_trigger),
    .spi_run_enable   (spi_run_enable),
    .busy             (busy),
    .error            (error),
    .error_code       (error_code),
    .active_sel       (active_sel)
  );

  typedef struct {
    int kind;
    int m;
    int d;
    int sel;
    int err;
    int code;
    int en;
    int bsy;
    int aux;
  } ev_t;

  localparam int EV_RUN  = 0;
  localparam int EV_DROP = 1;
  localparam int EV_TRIG = 2;
  localparam int EV_ERR  = 3;

  ev_t  exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   lock_stamp = 0;
  int   rst_stamp  = 0;
  int   trig_count = 0;
  int   ev_count   = 0;
  int   glitch_cnt = 0;
  logic dcm_hang   = 1'b0;

  always @(posedge okClk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int m, input int d, input int sel, input int err,
                           input int code, input int en, input int bsy, input int aux);
    ev_t e;
    e.kind = kind; e.m = m; e.d = d; e.sel = sel; e.err = err;
    e.code = code; e.en = en; e.bsy = bsy; e.aux = aux;
    exp_q.push_back(e);
  endtask

  function automatic ev_t snap(input int kind, input int aux);
    ev_t s;
    s.kind = kind; s.m = int'(M); s.d = int'(D); s.sel = int'(active_sel);
    s.err = int'(error); s.code = int'(error_code); s.en = int'(spi_run_enable);
    s.bsy = int'(busy); s.aux = aux;
    return s;
  endfunction

  task automatic report(input ev_t got);
    ev_t e;
    ev_count++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected event %0d: got kind %0d (M=%0d D=%0d), required none",
               ev_count, got.kind, got.m, got.d);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("ev%0d kind", ev_count), got.kind, e.kind);
      chk($sformatf("ev%0d M", ev_count), got.m, e.m);
      chk($sformatf("ev%0d D", ev_count), got.d, e.d);
      chk($sformatf("ev%0d active_sel", ev_count), got.sel, e.sel);
      chk($sformatf("ev%0d error", ev_count), got.err, e.err);
      chk($sformatf("ev%0d error_code", ev_count), got.code, e.code);
      chk($sformatf("ev%0d spi_run_enable", ev_count), got.en, e.en);
      chk($sformatf("ev%0d busy", ev_count), got.bsy, e.bsy);
      chk($sformatf("ev%0d aux", ev_count), got.aux, e.aux);
    end
  endtask

  // Monitor: RUN aux = cycles from lock (or reset release) to enable; TRIG aux = pulse width.
  initial begin : monitor
    logic       p_en, p_trig, p_err;
    logic [1:0] p_code;
    ev_t        tr;
    int         w;
    int         ls;
    p_en = 1'b0; p_trig = 1'b0; p_err = 1'b0; p_code = 2'd0; w = 0;
    tr = snap(EV_TRIG, 0);
    forever begin
      @(negedge okClk);
      if (!reset) begin
        ls = (lock_stamp > rst_stamp) ? lock_stamp : rst_stamp;
        if (spi_run_enable && !p_en) report(snap(EV_RUN, cyc - ls));
        if (!spi_run_enable && p_en) report(snap(EV_DROP, 0));
        if (DCM_prog_trigger && !p_trig) begin
          tr = snap(EV_TRIG, 0);
          w = 0;
          trig_count++;
        end
        if (DCM_prog_trigger) w++;
        if (!DCM_prog_trigger && p_trig) begin
          tr.aux = w;
          report(tr);
        end
        if (error && (!p_err || error_code != p_code)) report(snap(EV_ERR, 0));
      end
      p_en = spi_run_enable; p_trig = DCM_prog_trigger; p_err = error; p_code = error_code;
    end
  end

  // Clock generator model: PROGDONE falls then rises after a trigger, LOCKED follows.
  initial begin : dcm_model
    int seen;
    seen = 0;
    DCM_prog_done = 1'b1;
    dcm_locked    = 1'b1;
    forever begin
      @(negedge okClk);
      if (glitch_cnt != seen) begin
        seen++;
        dcm_locked = 1'b0;
        @(negedge okClk);
        dcm_locked = 1'b1;
        lock_stamp = cyc;
      end else if (DCM_prog_trigger && !dcm_hang) begin
        repeat (2) @(negedge okClk);
        DCM_prog_done = 1'b0;
        dcm_locked    = 1'b0;
        repeat (8) @(negedge okClk);
        DCM_prog_done = 1'b1;
        repeat (4) @(negedge okClk);
        dcm_locked = 1'b1;
        lock_stamp = cyc;
      end
    end
  end

  task automatic pulse(input int sel);
    @(negedge okClk);
    rate_sel    = 5'(sel);
    rate_update = 1'b1;
    @(negedge okClk);
    rate_update = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge okClk);
      n++;
    end
    chk({name, " pending events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_trig(input int prev, input int budget);
    int n;
    n = 0;
    while (trig_count == prev && n < budget) begin
      @(negedge okClk);
      n++;
    end
    chk("trigger seen", trig_count, prev + 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " M"}, int'(M), 42);
    chk({tag, " D"}, int'(D), 25);
    chk({tag, " active_sel"}, int'(active_sel), 16);
    chk({tag, " trigger"}, int'(DCM_prog_trigger), 0);
    chk({tag, " run_enable"}, int'(spi_run_enable), 0);
    chk({tag, " busy"}, int'(busy), 1);
    chk({tag, " error"}, int'(error), 0);
    chk({tag, " error_code"}, int'(error_code), 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tc;
    reset = 1'b1; rate_sel = 5'd0; rate_update = 1'b0; spi_idle = 1'b1;
    repeat (4) @(negedge okClk);
    check_reset_values("reset");

    // Power-up: enable 2 sync + 64 stable cycles after release with LOCKED already high.
    expect_ev(EV_RUN, 42, 25, 16, 0, 0, 1, 0, 66);
    reset = 1'b0;
    rst_stamp = cyc;
    drain("powerup", 300);

    // Normal change to index 8.
    expect_ev(EV_DROP, 42, 25, 16, 0, 0, 0, 1, 0);
    expect_ev(EV_TRIG, 7, 25, 8, 0, 0, 0, 1, 2);
    expect_ev(EV_RUN, 7, 25, 8, 0, 0, 1, 0, 66);
    pulse(8);
    drain("rate8", 500);

    // SPI not idle: sequence stalls in STOP without triggering.
    spi_idle = 1'b0;
    expect_ev(EV_DROP, 7, 25, 8, 0, 0, 0, 1, 0);
    pulse(5);
    drain("stop", 50);
    tc = trig_count;
    repeat (100) @(negedge okClk);
    chk("stall no trigger", trig_count, tc);
    chk("stall busy", int'(busy), 1);
    chk("stall M held", int'(M), 7);
    expect_ev(EV_TRIG, 21, 125, 5, 0, 0, 0, 1, 2);
    expect_ev(EV_RUN, 21, 125, 5, 0, 0, 1, 0, 66);
    spi_idle = 1'b1;
    drain("rate5", 500);

    // Request during WAIT_LOCK is ignored.
    expect_ev(EV_DROP, 21, 125, 5, 0, 0, 0, 1, 0);
    expect_ev(EV_TRIG, 7, 10, 12, 0, 0, 0, 1, 2);
    expect_ev(EV_RUN, 7, 10, 12, 0, 0, 1, 0, 66);
    tc = trig_count;
    pulse(12);
    wait_trig(tc, 50);
    repeat (30) @(negedge okClk);
    pulse(3);
    drain("rate12", 500);
    chk("busy request no retrigger", trig_count, tc + 1);
    chk("busy request no error", int'(error), 0);

    // One-cycle loss of lock in RUN.
    expect_ev(EV_DROP, 7, 10, 12, 0, 0, 0, 1, 0);
    expect_ev(EV_RUN, 7, 10, 12, 0, 0, 1, 0, 66);
    glitch_cnt++;
    drain("lock glitch", 300);

    // Out-of-range index in RUN: error code 1, rate and enable unchanged.
    expect_ev(EV_ERR, 7, 10, 12, 1, 1, 1, 0, 0);
    pulse(25);
    drain("bad index", 20);
    repeat (5) @(negedge okClk);
    chk("bad index enable", int'(spi_run_enable), 1);
    chk("bad index M", int'(M), 7);
    chk("bad index D", int'(D), 10);

    // PROGDONE never falls: timeout to ERR code 3 (error stays sticky from code 1 meanwhile).
    dcm_hang = 1'b1;
    expect_ev(EV_DROP, 7, 10, 12, 1, 1, 0, 1, 0);
    expect_ev(EV_TRIG, 7, 125, 0, 1, 1, 0, 1, 2);
    expect_ev(EV_ERR, 7, 125, 0, 1, 3, 0, 0, 0);
    pulse(0);
    drain("progdone timeout", 70000);

    // Recovery from ERR with a valid request.
    dcm_hang = 1'b0;
    expect_ev(EV_TRIG, 14, 125, 3, 0, 0, 0, 1, 2);
    expect_ev(EV_RUN, 14, 125, 3, 0, 0, 1, 0, 66);
    pulse(3);
    chk("recover error", int'(error), 0);
    chk("recover error_code", int'(error_code), 0);
    drain("recover", 500);

    // Reset mid-sequence returns to defaults.
    expect_ev(EV_DROP, 14, 125, 3, 0, 0, 0, 1, 0);
    tc = trig_count;
    pulse(17);
    wait_trig(tc, 50);
    chk("midseq M loaded", int'(M), 56);
    reset = 1'b1;
    @(negedge okClk);
    check_reset_values("midreset");
    repeat (20) @(negedge okClk);
    drain("midreset", 1);
    expect_ev(EV_RUN, 42, 25, 16, 0, 0, 1, 0, 66);
    reset = 1'b0;
    rst_stamp = cyc;
    drain("after midreset", 300);

    repeat (10) @(negedge okClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
